// File: rtl/cla_pkg.sv
// ============================================================================
// cla_pkg : shared width constant and result types for the CLA adder and subtractor
// Revision: 1.0
// ============================================================================
`default_nettype none

package cla_pkg;

    localparam int CLA_W = 5;

    typedef logic [CLA_W-1:0] operand_t;

    typedef struct packed {
        operand_t d;
        logic     bout;
    } result_t;

endpackage

`default_nettype wire

// File: rtl/bla_core.sv
// ============================================================================
// bla_core : combinational borrow-lookahead difference of the stage-1 operands
// Revision: 1.0
// ============================================================================
`default_nettype none

module bla_core
    import cla_pkg::*;
#(
    parameter int W = CLA_W
) (
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic         bin1,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W:0]   w_b;
    logic         w_term;
    logic         w_acc;

    assign w_g = ~a1 & b1;
    assign w_p = ~(a1 ^ b1);

    // Each borrow is an independent sum of products of g/p terms and bin1,
    // so no borrow is computed from a previously computed borrow.
    always_comb begin
        w_b    = '0;
        w_term = 1'b0;
        w_acc  = 1'b0;
        w_b[0] = bin1;
        for (int i = 0; i < W; i++) begin
            w_term = bin1;
            for (int k = 0; k <= i; k++) begin
                w_term = w_term & w_p[k];
            end
            w_acc = w_term;
            for (int j = 0; j <= i; j++) begin
                w_term = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    w_term = w_term & w_p[k];
                end
                w_acc = w_acc | w_term;
            end
            w_b[i+1] = w_acc;
        end
    end

    assign d    = a1 ^ b1 ^ w_b[W-1:0];
    assign bout = w_b[W];

endmodule

`default_nettype wire

// File: rtl/cla_sub.sv
// ============================================================================
// cla_sub : two-stage registered borrow-lookahead subtractor, valid/ready both sides
// Optional build macro CLA_SUB_SAT_EN: clamp D to zero whenever a borrow-out occurs
// Revision: 1.0
// ============================================================================
`default_nettype none

module cla_sub
    import cla_pkg::*;
#(
    parameter int W = CLA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Bin,
    output logic [W-1:0] A1,
    output logic [W-1:0] B1,
    output logic         Bin1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] D,
    output logic         Bout
);

    logic         s1_v_q, s1_v_d;
    logic         s2_v_q, s2_v_d;
    logic [W-1:0] a1_q, a1_d;
    logic [W-1:0] b1_q, b1_d;
    logic         bin1_q, bin1_d;
    logic [W-1:0] d_q, d_d;
    logic         bout_q, bout_d;

    logic [W-1:0] w_core_d;
    logic         w_core_bout;
    logic         w_accept;
    logic         w_adv;
    logic         w_fire;

    bla_core #(.W(W)) u_core (
        .a1   (a1_q),
        .b1   (b1_q),
        .bin1 (bin1_q),
        .d    (w_core_d),
        .bout (w_core_bout)
    );

    assign in_ready = !rst && (!s1_v_q || !s2_v_q || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_adv    = s1_v_q && (!s2_v_q || out_ready);
    assign w_fire   = s2_v_q && out_ready;

    always_comb begin
        s1_v_d = s1_v_q;
        s2_v_d = s2_v_q;
        a1_d   = a1_q;
        b1_d   = b1_q;
        bin1_d = bin1_q;
        d_d    = d_q;
        bout_d = bout_q;

        // Clear-then-set ordering lets a same-cycle refill win over a drain.
        if (w_adv) begin
            s1_v_d = 1'b0;
        end
        if (w_accept) begin
            s1_v_d = 1'b1;
            a1_d   = A;
            b1_d   = B;
            bin1_d = Bin;
        end

        if (w_fire) begin
            s2_v_d = 1'b0;
        end
        if (w_adv) begin
            s2_v_d = 1'b1;
            bout_d = w_core_bout;
`ifdef CLA_SUB_SAT_EN
            d_d    = w_core_bout ? '0 : w_core_d;
`else
            d_d    = w_core_d;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            bin1_q <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            bin1_q <= bin1_d;
            d_q    <= d_d;
            bout_q <= bout_d;
        end
    end

    assign A1        = a1_q;
    assign B1        = b1_q;
    assign Bin1      = bin1_q;
    assign out_valid = s2_v_q;
    assign D         = d_q;
    assign Bout      = bout_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_sub.sv
// ============================================================================
// tb_cla_sub : randomized and directed scoreboard bench for cla_sub (W = 5)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cla_sub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] A = '0;
    logic [4:0] B = '0;
    logic       Bin = 1'b0;
    logic [4:0] A1;
    logic [4:0] B1;
    logic       Bin1;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] D;
    logic       Bout;

    typedef struct {
        logic [4:0] d;
        logic       b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic done = 1'b0;

    logic       prev_stall = 1'b0;
    logic [4:0] prev_d = '0;
    logic       prev_bout = 1'b0;

    cla_sub #(.W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .A1        (A1),
        .B1        (B1),
        .Bin1      (Bin1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction, wrapped or clamped.
    function automatic exp_t model(input int a, input int b, input int bin);
        exp_t e;
        int   diff;
        diff = a - b - bin;
        e.b  = (diff < 0);
        e.d  = 5'(diff);
`ifdef CLA_SUB_SAT_EN
        if (e.b) e.d = '0;
`endif
        return e;
    endfunction

    // Called and returns at posedge+1; pushes the expectation on the accepting cycle.
    task automatic send(input int a, input int b, input int bin, output int waits);
        A        = 5'(a);
        B        = 5'(b);
        Bin      = 1'(bin);
        in_valid = 1'b1;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(model(a, b, bin));
                break;
            end
            waits++;
            if (waits > 500) begin
                chk("send_timeout", waits, 0);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every output handshake and checks stall stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall && out_valid) begin
                chk("stall_hold_d", int'(D), int'(prev_d));
                chk("stall_hold_bout", int'(Bout), int'(prev_bout));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result_d", int'(D), int'(e.d));
                    chk("result_bout", int'(Bout), int'(e.b));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = D;
            prev_bout  = Bout;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int w;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_a1", int'(A1), 0);
        chk("rst_d", int'(D), 0);
        chk("rst_bout", int'(Bout), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // 31 - 31 - 1 : full wrap, checks latency too
        out_ready = 1'b1;
        send(31, 31, 1, w);
        @(negedge clk);
        chk("lat_s1_only_out_valid", int'(out_valid), 0);
        chk("cap_a1", int'(A1), 31);
        chk("cap_b1", int'(B1), 31);
        chk("cap_bin1", int'(Bin1), 1);
        @(negedge clk);
        chk("lat_out_valid", int'(out_valid), 1);
`ifdef CLA_SUB_SAT_EN
        chk("tp1_d", int'(D), 0);
`else
        chk("tp1_d", int'(D), 31);
`endif
        chk("tp1_bout", int'(Bout), 1);
        @(posedge clk);
        #1;
        drain();

        send(30, 10, 0, w);
        send(16, 1, 0, w);
        drain();

        // Backpressure: two beats fill the pipe, third waits
        out_ready = 1'b0;
        send(5, 3, 0, w);
        send(7, 7, 0, w);
        @(negedge clk);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_out_valid", int'(out_valid), 1);
        chk("bp_d", int'(D), 2);
        @(posedge clk);
        #1;
        fork
            send(0, 1, 0, w);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Back-to-back stream
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1), w);
            chk("stream_in_ready_waits", w, 0);
            if (i >= 1) chk("stream_out_valid", int'(out_valid), 1);
        end
        drain();

        // Random traffic with random backpressure
        done = 1'b0;
        fork
            begin
                int ww;
                for (int i = 0; i < 80; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1), ww);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset while FULL
        out_ready = 1'b0;
        send(9, 4, 0, w);
        send(3, 2, 1, w);
        @(negedge clk);
        chk("full_before_rst", int'(out_valid && !in_ready), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_a1", int'(A1), 0);
        chk("midrst_b1", int'(B1), 0);
        chk("midrst_bin1", int'(Bin1), 0);
        chk("midrst_d", int'(D), 0);
        chk("midrst_bout", int'(Bout), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("postrst_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("postrst_no_stale", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;

        send(12, 5, 1, w);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
